// File: rtl/dram_burst_reader.sv
// dram_burst_reader
//   Read-back engine for the DDR3 event store. A start pulse fetches num_words
//   consecutive DATA_W-bit words from start_addr using Avalon-MM burst reads.
//   Returned words go through an internal show-ahead FIFO and come out on a
//   valid/ready stream. Read commands are credit-limited against the free FIFO
//   space, so returned data can never overflow the FIFO.
//
//   Optional feature: define DRB_OUT_LAST_EN to add the out_last port. It marks
//   the final word of a transfer on the out stream.
//
// Ports
//   avalon_clk, rst_n        clock, synchronous active-low reset
//   start/start_addr/num_words  transfer request (one-cycle start pulse)
//   busy, done, words_read   transfer status; done is a one-cycle pulse
//   avl_*                    Avalon-MM read master (burst reads)
//   out_data/out_valid/out_ready  output stream (out_last when enabled)
module dram_burst_reader #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 256,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 16
) (
    input  logic              avalon_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_read,
    output logic              avl_read,
    output logic [ADDR_W-1:0] avl_address,
    output logic [4:0]        avl_burstcount,
    output logic              avl_beginbursttransfer,
    input  logic              avl_waitrequest_n,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
`ifdef DRB_OUT_LAST_EN
    output logic              out_last,
`endif
    input  logic              out_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = 5;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   issue_rem_q;
    logic [LEN_W-1:0]   recv_rem_q;
    logic [LEN_W-1:0]   words_read_q;
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic               pending_q;     // command presented last cycle, not yet accepted
    logic               zero_done_q;   // done pulse for a zero-length request
`ifdef DRB_OUT_LAST_EN
    logic [LEN_W-1:0]   num_words_q;
`endif

    logic [ADDR_W:0]    to_top;
    logic [LEN_W-1:0]   bsize;
    logic [CNT_W-1:0]   avail;
    logic               credit_ok;
    logic               start_ok;
    logic               accept;
    logic               push;
    logic               pop;

    // Burst size: BURST_LEN, the remaining words, and never past the top of
    // the address space so a burst does not straddle the wrap to address 0.
    always_comb begin
        to_top = {1'b1, {ADDR_W{1'b0}}} - {1'b0, addr_q};
        bsize  = (issue_rem_q > LEN_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : issue_rem_q;
        if ((to_top < (ADDR_W+1)'(BURST_LEN)) && (LEN_W'(to_top[BC_W-1:0]) < bsize))
            bsize = LEN_W'(to_top[BC_W-1:0]);
    end

    // fifo_cnt + inflight never exceeds FIFO_DEPTH, so this cannot underflow.
    assign avail     = CNT_W'(FIFO_DEPTH) - fifo_cnt_q - inflight_q;
    assign credit_ok = 32'(avail) >= 32'(bsize);

    assign start_ok  = (state_q == IDLE) && start && (num_words != '0);
    assign accept    = avl_read && avl_waitrequest_n;
    // Returns outside a transfer are stale (e.g. issued before a reset).
    assign push      = avl_readdatavalid && ((state_q == ISSUE) || (state_q == DRAIN));
    assign pop       = out_valid && out_ready;
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

    // FSM next state and control outputs
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = zero_done_q;
        avl_read = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                // Credit only grows while a command waits, so once presented
                // it stays presented until accepted.
                avl_read = pending_q || credit_ok;
                if (accept && (issue_rem_q == bsize)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Looking at the post-pop count lets done follow the last pop
                // by exactly one cycle.
                if ((recv_rem_q == '0) && (fifo_cnt_d == '0)) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign avl_address            = avl_read ? addr_q : '0;
    assign avl_burstcount         = avl_read ? bsize[BC_W-1:0] : '0;
    assign avl_beginbursttransfer = avl_read && !pending_q;

    always_ff @(posedge avalon_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_rem_q  <= '0;
            recv_rem_q   <= '0;
            words_read_q <= '0;
            inflight_q   <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= 1'b0;
            zero_done_q  <= 1'b0;
`ifdef DRB_OUT_LAST_EN
            num_words_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= avl_read && !avl_waitrequest_n;
            zero_done_q <= (state_q == IDLE) && start && (num_words == '0);
            if (start_ok) begin
                addr_q       <= start_addr;
                issue_rem_q  <= num_words;
                recv_rem_q   <= num_words;
                words_read_q <= '0;
`ifdef DRB_OUT_LAST_EN
                num_words_q  <= num_words;
`endif
            end else begin
                if (accept) begin
                    addr_q      <= addr_q + ADDR_W'(bsize);
                    issue_rem_q <= issue_rem_q - bsize;
                end
                if (push) recv_rem_q   <= recv_rem_q - LEN_W'(1);
                if (pop)  words_read_q <= words_read_q + LEN_W'(1);
            end
            inflight_q <= inflight_q + (accept ? CNT_W'(bsize) : CNT_W'(0)) - CNT_W'(push);
            fifo_cnt_q <= fifo_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO storage, no reset so it maps onto RAM.
    always_ff @(posedge avalon_clk) begin
        if (push) mem[wr_ptr_q] <= avl_readdata;
    end

    assign out_valid  = (fifo_cnt_q != '0);
    assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
    assign words_read = words_read_q;
`ifdef DRB_OUT_LAST_EN
    assign out_last   = out_valid && (words_read_q == num_words_q - LEN_W'(1));
`endif

    // A push into a full FIFO would mean the credit accounting is broken.
    always @(posedge avalon_clk) begin
        if (rst_n && push && !pop)
            assert (fifo_cnt_q != CNT_W'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_dram_burst_reader.sv
module tb_dram_burst_reader;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;

    logic              avalon_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [LEN_W-1:0]  num_words = '0;
    logic              busy, done;
    logic [LEN_W-1:0]  words_read;
    logic              avl_read;
    logic [ADDR_W-1:0] avl_address;
    logic [4:0]        avl_burstcount;
    logic              avl_beginbursttransfer;
    logic              avl_waitrequest_n = 1'b1;
    logic [DATA_W-1:0] avl_readdata = '0;
    logic              avl_readdatavalid = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
`ifdef DRB_OUT_LAST_EN
    logic              out_last;
`endif

    dram_burst_reader dut (
        .avalon_clk(avalon_clk), .rst_n(rst_n), .start(start),
        .start_addr(start_addr), .num_words(num_words),
        .busy(busy), .done(done), .words_read(words_read),
        .avl_read(avl_read), .avl_address(avl_address),
        .avl_burstcount(avl_burstcount),
        .avl_beginbursttransfer(avl_beginbursttransfer),
        .avl_waitrequest_n(avl_waitrequest_n), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .out_data(out_data), .out_valid(out_valid),
`ifdef DRB_OUT_LAST_EN
        .out_last(out_last),
`endif
        .out_ready(out_ready)
    );

    always #5 avalon_clk = ~avalon_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge avalon_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory content: a fixed scramble of the word address.
    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int j = 0; j < 8; j++)
            d[j*32 +: 32] = {7'd0, a} * 32'h9E3779B1 + 32'(j) * 32'h01010101;
        return d;
    endfunction

    // Slave / scoreboard state
    logic [ADDR_W-1:0] cmd_addr[$];
    logic [4:0]        cmd_len[$];
    logic [ADDR_W-1:0] ret_addr[$];
    int                ret_due[$];
    int  stall_left = 0;
    bit  hold_ret = 0;
    int  first_pres = 0, first_beg = 0;
    int  done_cnt = 0, last_cnt = 0;

    // Transfer model
    bit                m_active = 0;
    int                m_busy_from = 0;
    logic [ADDR_W-1:0] m_start_addr = '0;
    int                m_num = 0;
    int                m_popped = 0;
    int                m_fifo = 0;
    int                m_req = 0;
    int                m_done_due = -10;
    bit                push_next = 0;
    bit                prev_pend = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [4:0]        prev_bc = '0;
    bit                rst_low_prev = 0;

    always @(negedge avalon_clk) begin
        bit exp_busy, exp_valid, exp_done, acc, drove;
        if (!rst_n) begin
            if (rst_low_prev) begin
                chk("rst avl_read", avl_read, 0);
                chk("rst avl_address", avl_address, 0);
                chk("rst avl_burstcount", avl_burstcount, 0);
                chk("rst begin", avl_beginbursttransfer, 0);
                chk("rst busy", busy, 0);
                chk("rst done", done, 0);
                chk("rst words_read", words_read, 0);
                chk("rst out_valid", out_valid, 0);
                chk("rst out_data", out_data, 0);
`ifdef DRB_OUT_LAST_EN
                chk("rst out_last", out_last, 0);
`endif
            end
            rst_low_prev = 1;
            m_active = 0; m_fifo = 0; m_popped = 0; m_req = 0; m_done_due = -10;
            push_next = 0; prev_pend = 0;
            avl_readdatavalid = 0; avl_waitrequest_n = 1;
        end else begin
            rst_low_prev = 0;
            if (push_next) m_fifo++;
            exp_busy  = m_active && (cyc >= m_busy_from);
            exp_valid = (m_fifo > 0);
            exp_done  = (cyc == m_done_due);

            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("out_valid", out_valid, exp_valid);
            chk("words_read", words_read, m_popped);
            if (exp_valid && out_valid)
                chk("out_data", out_data, word_of(m_start_addr + ADDR_W'(m_popped)));
`ifdef DRB_OUT_LAST_EN
            chk("out_last", out_last, exp_valid && (m_popped == m_num - 1));
            if (out_last && out_valid && out_ready) last_cnt++;
`endif
            chk("credit limit", (m_req - m_popped) <= 64, 1);
            if (done) done_cnt++;

            // Command presentation must hold until accepted.
            if (prev_pend) begin
                chk("held read", avl_read, 1);
                chk("held address", avl_address, prev_addr);
                chk("held burstcount", avl_burstcount, prev_bc);
                chk("begin on held cmd", avl_beginbursttransfer, 0);
            end else if (avl_read) begin
                chk("begin on new cmd", avl_beginbursttransfer, 1);
            end else begin
                chk("begin idle", avl_beginbursttransfer, 0);
            end

            // Avalon slave
            if (avl_read && stall_left > 0) begin
                avl_waitrequest_n = 0;
                stall_left--;
            end else begin
                avl_waitrequest_n = 1;
            end
            if (avl_read && cmd_addr.size() == 0) begin
                first_pres++;
                if (avl_beginbursttransfer) first_beg++;
            end
            acc = avl_read && avl_waitrequest_n;
            if (acc) begin
                cmd_addr.push_back(avl_address);
                cmd_len.push_back(avl_burstcount);
                for (int i = 0; i < int'(avl_burstcount); i++) begin
                    ret_addr.push_back(avl_address + ADDR_W'(i));
                    ret_due.push_back(cyc + 2);
                end
                m_req += int'(avl_burstcount);
            end
            prev_pend = avl_read && !avl_waitrequest_n;
            prev_addr = avl_address;
            prev_bc   = avl_burstcount;

            drove = 0;
            if (!hold_ret && ret_addr.size() > 0 && ret_due[0] <= cyc) begin
                avl_readdatavalid = 1;
                avl_readdata = word_of(ret_addr.pop_front());
                void'(ret_due.pop_front());
                drove = 1;
            end else begin
                avl_readdatavalid = 0;
            end
            push_next = drove && exp_busy;

            if (exp_valid && out_ready) begin
                m_popped++;
                m_fifo--;
                if (m_active && m_popped == m_num) begin
                    m_done_due = cyc + 1;
                    m_active = 0;
                end
            end

            if (start && !m_active) begin
                if (num_words == 0) begin
                    m_done_due = cyc + 1;
                end else begin
                    m_active = 1;
                    m_busy_from = cyc + 1;
                    m_start_addr = start_addr;
                    m_num = int'(num_words);
                    m_popped = 0;
                    m_req = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge avalon_clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input int n);
        start = 1; start_addr = a; num_words = LEN_W'(n);
        tick();
        start = 0;
    endtask

    task automatic clear_log();
        cmd_addr.delete(); cmd_len.delete();
        first_pres = 0; first_beg = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0;
        bit seen;
        c0 = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_cnt != c0) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
        repeat (2) tick();
    endtask

    task automatic chk_cmd(input string name, input int idx, input logic [ADDR_W-1:0] a, input int len);
        if (idx < cmd_addr.size()) begin
            chk({name, " addr"}, cmd_addr[idx], a);
            chk({name, " len"}, cmd_len[idx], len);
        end else begin
            chk({name, " present"}, 0, 1);
        end
    endtask

    initial begin
        int c0, lc0;
        bit got;
        repeat (3) tick();
        rst_n = 1;
        repeat (2) tick();

        // 40 words from 0x100, with a start pulse while busy that must be ignored
        clear_log();
        do_start(25'h100, 40);
        repeat (10) tick();
        do_start(25'h999, 5);
        wait_done("40-word transfer", 300);
        chk("t1 words_read", words_read, 40);
        chk("t1 cmd count", cmd_addr.size(), 3);
        chk_cmd("t1 cmd0", 0, 25'h100, 16);
        chk_cmd("t1 cmd1", 1, 25'h110, 16);
        chk_cmd("t1 cmd2", 2, 25'h120, 8);

        // waitrequest held low for 3 cycles on the first command
        clear_log();
        stall_left = 3;
        do_start(25'h200, 16);
        wait_done("stalled transfer", 200);
        chk("t2 presentation cycles", first_pres, 4);
        chk("t2 begin count", first_beg, 1);
        chk("t2 cmd count", cmd_addr.size(), 1);
        chk_cmd("t2 cmd0", 0, 25'h200, 16);
        chk("t2 words_read", words_read, 16);

        // Backpressure: credit stops issue at FIFO_DEPTH words
        clear_log();
        out_ready = 0;
        do_start(25'h2000, 200);
        repeat (150) tick();
        chk("t3 words requested", m_req, 64);
        chk("t3 avl_read idle", avl_read, 0);
        chk("t3 out_valid", out_valid, 1);
        chk("t3 busy", busy, 1);
        out_ready = 1;
        wait_done("backpressure transfer", 1000);
        chk("t3 words_read", words_read, 200);
        chk("t3 cmd count", cmd_addr.size(), 13);

        // Address wrap
        clear_log();
        do_start(25'h1FFFFF8, 16);
        wait_done("wrap transfer", 200);
        chk("t4 cmd count", cmd_addr.size(), 2);
        chk_cmd("t4 cmd0", 0, 25'h1FFFFF8, 8);
        chk_cmd("t4 cmd1", 1, 25'h0000000, 8);

        // Zero-length request
        clear_log();
        c0 = done_cnt;
        do_start(25'h500, 0);
        repeat (3) tick();
        chk("t5 done pulses", done_cnt - c0, 1);
        chk("t5 no commands", cmd_addr.size(), 0);
        chk("t5 words_read kept", words_read, 16);

        // Reset with 10 words in flight
        clear_log();
        hold_ret = 1;
        do_start(25'h3000, 10);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (m_req == 10) got = 1;
        end
        chk("t6 cmd accepted", got, 1);
        repeat (2) tick();
        chk("t6 in flight", ret_addr.size(), 10);
        c0 = done_cnt;
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        hold_ret = 0;
        repeat (20) tick();
        chk("t6 stale drained", ret_addr.size(), 0);
        chk("t6 no done", done_cnt - c0, 0);
        chk("t6 out_valid", out_valid, 0);
        chk("t6 words_read", words_read, 0);
        chk("t6 busy", busy, 0);

        clear_log();
        lc0 = last_cnt;
        do_start(25'h4000, 16);
        wait_done("post-reset transfer", 200);
        chk("t6 new words_read", words_read, 16);
        chk_cmd("t6 cmd0", 0, 25'h4000, 16);
`ifdef DRB_OUT_LAST_EN
        chk("t6 out_last count", last_cnt - lc0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
